// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status-class nibbles, transmit FSM states and
// the status-byte length decode used by the transmitter.
package midi_pkg;

    localparam logic [3:0] ST_NOTE_OFF   = 4'h8;
    localparam logic [3:0] ST_NOTE_ON    = 4'h9;
    localparam logic [3:0] ST_POLY_AT    = 4'hA;
    localparam logic [3:0] ST_CONTROL    = 4'hB;
    localparam logic [3:0] ST_PROGRAM    = 4'hC;
    localparam logic [3:0] ST_CHAN_AT    = 4'hD;
    localparam logic [3:0] ST_PITCHBEND  = 4'hE;
    localparam logic [3:0] ST_SYSTEM     = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_ST = 2'd1,
        SEND_D1 = 2'd2,
        SEND_D2 = 2'd3
    } tx_state_e;

    // Total bytes in a message (status included); 0 for a non-status byte.
    function automatic logic [1:0] msg_len_f(input logic [7:0] status);
        logic [1:0] len;
        len = 2'd0;
        case (status[7:4])
            ST_NOTE_OFF, ST_NOTE_ON, ST_POLY_AT, ST_CONTROL, ST_PITCHBEND: len = 2'd3;
            ST_PROGRAM, ST_CHAN_AT: len = 2'd2;
            ST_SYSTEM: begin
                case (status[3:0])
                    4'h1, 4'h3: len = 2'd2;
                    4'h2:       len = 2'd3;
                    default:    len = 2'd1;
                endcase
            end
            default: len = 2'd0;
        endcase
        return len;
    endfunction

    function automatic logic is_channel_f(input logic [7:0] status);
        return status[7] && (status[7:4] != ST_SYSTEM);
    endfunction

    // Running-status register update: channel messages load, system common
    // cancels, realtime leaves it alone.
    function automatic logic [7:0] next_cur_status_f(input logic [7:0] status,
                                                     input logic [7:0] cur);
        logic [7:0] nxt;
        if (is_channel_f(status)) begin
            nxt = status;
        end else if (!status[3]) begin
            nxt = 8'h00;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// Single-byte UART serialiser: start bit, 8 data bits LSB first, stop bit,
// each BIT_CYC clocks; done is high during the final cycle of the stop bit.
module midi_uart_tx #(
    parameter int BIT_CYC = 1600
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int             CW        = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 2;
    localparam logic [CW-1:0]  CYC_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0]  CYC_PRE   = CW'(BIT_CYC - 2);
    localparam logic [CW-1:0]  CYC_ONE   = CW'(1);
    localparam logic [3:0]     BIT_DATA7 = 4'd8;
    localparam logic [3:0]     BIT_STOP  = 4'd9;

    if (BIT_CYC < 2) begin : g_bad_bit_cyc
        $error("midi_uart_tx: BIT_CYC must be at least 2");
    end

    logic          active_q;
    logic          tx_q;
    logic          done_q;
    logic [CW-1:0] cyc_q;
    logic [3:0]    bit_q;
    logic [7:0]    data_q;

    // bit_q: 0 = start, 1..8 = data bits 0..7, 9 = stop.
    // A load on the done cycle starts the next frame with no idle gap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            cyc_q    <= '0;
            bit_q    <= '0;
            data_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                active_q <= 1'b1;
                tx_q     <= 1'b0;
                data_q   <= data;
                cyc_q    <= '0;
                bit_q    <= '0;
            end else if (active_q) begin
                if (cyc_q == CYC_LAST) begin
                    cyc_q <= '0;
                    if (bit_q == BIT_STOP) begin
                        active_q <= 1'b0;
                        tx_q     <= 1'b1;
                    end else begin
                        bit_q <= bit_q + 4'd1;
                        tx_q  <= (bit_q == BIT_DATA7) ? 1'b1 : data_q[bit_q[2:0]];
                    end
                end else begin
                    cyc_q  <= cyc_q + CYC_ONE;
                    done_q <= (bit_q == BIT_STOP) && (cyc_q == CYC_PRE);
                end
            end
        end
    end

    assign tx   = tx_q;
    assign done = done_q;

endmodule

// File: rtl/midi_out_tx.sv
// MIDI message transmitter: one message per valid/ready handshake, length from
// the status byte. Define MIDI_TX_RUNNING_STATUS_EN to omit repeated channel status.
module midi_out_tx
    import midi_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 31250
) (
    input  logic       CLOCK_50,
    input  logic       reset_reg,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [7:0] msg_data1,
    input  logic [7:0] msg_data2,
    output logic       midi_tx,
    output logic       busy,
    output logic       byte_sent,
    output logic       msg_err,
    output logic [7:0] cur_status
);

    localparam int BIT_CYC = CLK_HZ / BAUD;

    if ((CLK_HZ % BAUD) != 0) begin : g_bad_rate
        $error("midi_out_tx: CLK_HZ must be an exact multiple of BAUD");
    end

    // Handshake: a message transfers on any edge where msg_valid & msg_ready.
    // msg_ready is high in IDLE and also in the last cycle of a message's final
    // stop bit, so the next message may start with no gap.

    tx_state_e  state_q;
    logic [7:0] d1_q;
    logic [7:0] d2_q;
    logic [1:0] len_q;
    logic [7:0] cur_status_q;
    logic       err_q;
    logic       rdy_en_q;

    logic       uart_done;
    logic       uart_tx;
    logic       uart_load;
    logic [7:0] uart_data;
    logic       last_byte;
    logic       free;
    logic       accept;
    logic       st_ok;
    logic       skip_st;
    logic [1:0] in_len;
    logic [7:0] d1_in;
    logic [7:0] d2_in;

    assign d1_in  = msg_data1 & 8'h7F;
    assign d2_in  = msg_data2 & 8'h7F;
    assign st_ok  = msg_status[7];
    assign in_len = msg_len_f(msg_status);

`ifdef MIDI_TX_RUNNING_STATUS_EN
    assign skip_st = is_channel_f(msg_status) && (msg_status == cur_status_q);
`else
    assign skip_st = 1'b0;
`endif

    always_comb begin
        last_byte = 1'b0;
        case (state_q)
            SEND_ST: last_byte = (len_q == 2'd1);
            SEND_D1: last_byte = (len_q == 2'd2);
            SEND_D2: last_byte = 1'b1;
            default: last_byte = 1'b0;
        endcase
    end

    assign free      = (state_q == IDLE) || (uart_done && last_byte);
    assign msg_ready = rdy_en_q && free;
    assign accept    = msg_valid && msg_ready;

    // First byte comes straight from the inputs on the accept edge; later
    // bytes come from the holding registers on the previous frame's done.
    always_comb begin
        uart_load = 1'b0;
        uart_data = msg_status;
        if (accept && st_ok) begin
            uart_load = 1'b1;
            uart_data = skip_st ? d1_in : msg_status;
        end else if (uart_done && !last_byte) begin
            uart_load = 1'b1;
            uart_data = (state_q == SEND_ST) ? d1_q : d2_q;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset_reg) begin
            state_q      <= IDLE;
            d1_q         <= '0;
            d2_q         <= '0;
            len_q        <= '0;
            cur_status_q <= '0;
            err_q        <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            err_q    <= 1'b0;
            if (accept) begin
                if (!st_ok) begin
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                end else begin
                    d1_q         <= d1_in;
                    d2_q         <= d2_in;
                    len_q        <= in_len;
                    cur_status_q <= next_cur_status_f(msg_status, cur_status_q);
                    state_q      <= skip_st ? SEND_D1 : SEND_ST;
                end
            end else if (uart_done) begin
                case (state_q)
                    SEND_ST: state_q <= last_byte ? IDLE : SEND_D1;
                    SEND_D1: state_q <= last_byte ? IDLE : SEND_D2;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    midi_uart_tx #(
        .BIT_CYC (BIT_CYC)
    ) u_uart (
        .clk_i (CLOCK_50),
        .rst_i (reset_reg),
        .load  (uart_load),
        .data  (uart_data),
        .tx    (uart_tx),
        .done  (uart_done)
    );

    assign midi_tx    = uart_tx;
    assign byte_sent  = uart_done;
    assign busy       = (state_q != IDLE) && !(uart_done && last_byte);
    assign msg_err    = err_q;
    assign cur_status = cur_status_q;

endmodule

// File: tb/tb_midi_out_tx.sv
// Bench for midi_out_tx with a short bit period; line, pulses and handshake are
// checked cycle by cycle against a message-level reference model.
module tb_midi_out_tx;

    localparam int BAUD   = 31250;
    localparam int CLK_HZ = BAUD * 16;
    localparam int B      = CLK_HZ / BAUD;
    localparam int FRAME  = 10 * B;

    logic       clk;
    logic       reset_reg;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] msg_status;
    logic [7:0] msg_data1;
    logic [7:0] msg_data2;
    logic       midi_tx;
    logic       busy;
    logic       byte_sent;
    logic       msg_err;
    logic [7:0] cur_status;

    int tests;
    int failed;

    logic [7:0] exp_q[$];
    logic       exp_err;
    logic [7:0] model_cur;

    midi_out_tx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .CLOCK_50   (clk),
        .reset_reg  (reset_reg),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_status (msg_status),
        .msg_data1  (msg_data1),
        .msg_data2  (msg_data2),
        .midi_tx    (midi_tx),
        .busy       (busy),
        .byte_sent  (byte_sent),
        .msg_err    (msg_err),
        .cur_status (cur_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bytes that must appear on the line for one message.
    function automatic void model_msg(input logic [7:0] st, input logic [7:0] d1,
                                      input logic [7:0] d2);
        int  n;
        bit  skip;
        exp_q.delete();
        exp_err = 1'b0;
        if (st < 8'h80) begin
            exp_err = 1'b1;
            return;
        end
        if (st <= 8'hBF || (st >= 8'hE0 && st <= 8'hEF) || st == 8'hF2) n = 3;
        else if (st <= 8'hDF || st == 8'hF1 || st == 8'hF3) n = 2;
        else n = 1;
        skip = 1'b0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
        skip = (st <= 8'hEF) && (st == model_cur);
`endif
        if (!skip) exp_q.push_back(st);
        if (n >= 2) exp_q.push_back(d1 & 8'h7F);
        if (n == 3) exp_q.push_back(d2 & 8'h7F);
        if (st <= 8'hEF) model_cur = st;
        else if (st <= 8'hF7) model_cur = 8'h00;
    endfunction

    // Expected line level n cycles after the accept edge.
    function automatic logic line_bit(input int n);
        int         pos;
        logic [7:0] b;
        b   = exp_q[n / FRAME];
        pos = (n % FRAME) / B;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic drive_accept(input logic [7:0] st, input logic [7:0] d1,
                                input logic [7:0] d2);
        msg_valid  = 1'b1;
        msg_status = st;
        msg_data1  = d1;
        msg_data2  = d2;
        @(posedge clk);
        @(negedge clk);
        msg_valid  = 1'b0;
        msg_status = 8'($urandom_range(0, 255));
        msg_data1  = 8'($urandom_range(0, 255));
        msg_data2  = 8'($urandom_range(0, 255));
    endtask

    // Sends one message from a negedge with msg_ready high and follows it to
    // the negedge of its final cycle, where the next message may be offered.
    task automatic send_msg(input logic [7:0] st, input logic [7:0] d1,
                            input logic [7:0] d2, input string tag);
        int total;
        int line_err;
        int pulse_err;
        int pulse_cnt;
        int hs_err;
        model_msg(st, d1, d2);
        tests++;
        if (msg_ready !== 1'b1) begin
            failed++;
            $display("FAIL %s ready_before: got %b want 1", tag, msg_ready);
        end
        drive_accept(st, d1, d2);
        if (exp_err) begin
            tests++;
            if (msg_err !== 1'b1 || midi_tx !== 1'b1 || msg_ready !== 1'b1 || busy !== 1'b0) begin
                failed++;
                $display("FAIL %s err_pulse: err=%b tx=%b ready=%b busy=%b want 1 1 1 0",
                         tag, msg_err, midi_tx, msg_ready, busy);
            end
            @(negedge clk);
            tests++;
            if (msg_err !== 1'b0 || midi_tx !== 1'b1 || msg_ready !== 1'b1) begin
                failed++;
                $display("FAIL %s err_once: err=%b tx=%b ready=%b want 0 1 1",
                         tag, msg_err, midi_tx, msg_ready);
            end
            return;
        end
        total = exp_q.size() * FRAME;
        line_err = 0; pulse_err = 0; pulse_cnt = 0; hs_err = 0;
        for (int n = 0; n < total; n++) begin
            if (n > 0) @(negedge clk);
            if (midi_tx !== line_bit(n)) line_err++;
            if (byte_sent !== ((n % FRAME) == FRAME - 1)) pulse_err++;
            if (byte_sent === 1'b1) pulse_cnt++;
            if (msg_ready !== (n == total - 1) || busy !== (n != total - 1)) hs_err++;
            if (msg_err !== 1'b0) hs_err++;
        end
        tests++;
        if (line_err != 0) begin
            failed++;
            $display("FAIL %s line: %0d wrong cycles over %0d bytes, want 0", tag, line_err, exp_q.size());
        end
        tests++;
        if (pulse_err != 0 || pulse_cnt != exp_q.size()) begin
            failed++;
            $display("FAIL %s byte_sent: %0d pulses (%0d misplaced), want %0d",
                     tag, pulse_cnt, pulse_err, exp_q.size());
        end
        tests++;
        if (hs_err != 0) begin
            failed++;
            $display("FAIL %s ready_busy: %0d wrong cycles, want 0", tag, hs_err);
        end
        tests++;
        if (cur_status !== model_cur) begin
            failed++;
            $display("FAIL %s cur_status: got %02h want %02h", tag, cur_status, model_cur);
        end
    endtask

    task automatic idle_cycles(input int k, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (midi_tx !== 1'b1 || busy !== 1'b0 || msg_ready !== 1'b1 || byte_sent !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL %s idle: %0d bad cycles, want 0", tag, bad);
        end
    endtask

    task automatic test_reset();
        reset_reg = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (midi_tx !== 1'b1 || msg_ready !== 1'b0 || busy !== 1'b0 || byte_sent !== 1'b0 ||
            msg_err !== 1'b0 || cur_status !== 8'h00) begin
            failed++;
            $display("FAIL reset_vals: tx=%b ready=%b busy=%b sent=%b err=%b cur=%02h want 1 0 0 0 0 00",
                     midi_tx, msg_ready, busy, byte_sent, msg_err, cur_status);
        end
        reset_reg = 1'b0;
        @(negedge clk);
        tests++;
        if (msg_ready !== 1'b1 || midi_tx !== 1'b1) begin
            failed++;
            $display("FAIL reset_release: ready=%b tx=%b want 1 1", msg_ready, midi_tx);
        end
        model_cur = 8'h00;
    endtask

    task automatic test_three_byte();
        send_msg(8'h90, 8'h3C, 8'h64, "note_on");
        idle_cycles(3, "note_on");
    endtask

    task automatic test_two_byte();
        send_msg(8'hC5, 8'h07, 8'($urandom_range(0, 255)), "prog_change");
        idle_cycles(2, "prog_change");
    endtask

    task automatic test_system();
        send_msg(8'hF8, 8'h11, 8'h22, "clock_rt");
        tests++;
        if (cur_status !== 8'hC5) begin
            failed++;
            $display("FAIL realtime_keeps_cur: got %02h want c5", cur_status);
        end
        send_msg(8'hF2, 8'h01, 8'h02, "song_pos");
        tests++;
        if (cur_status !== 8'h00) begin
            failed++;
            $display("FAIL syscommon_clears_cur: got %02h want 00", cur_status);
        end
        idle_cycles(2, "system");
    endtask

    task automatic test_running_status();
        send_msg(8'h90, 8'h3C, 8'h64, "rs_first");
        send_msg(8'h90, 8'h40, 8'h00, "rs_repeat");
        send_msg(8'hFE, 8'h00, 8'h00, "rs_active_sense");
        send_msg(8'h90, 8'h43, 8'h50, "rs_after_rt");
        idle_cycles(2, "rs");
    endtask

    task automatic test_invalid();
        send_msg(8'h3C, 8'h12, 8'h34, "bad_status");
        idle_cycles(4, "bad_status");
    endtask

    task automatic test_back_to_back();
        send_msg(8'hE3, 8'hFF, 8'h80, "b2b_bend");
        send_msg(8'hF1, 8'h55, 8'h00, "b2b_mtc");
        send_msg(8'h45, 8'h00, 8'h00, "b2b_bad");
        send_msg(8'hB1, 8'h07, 8'h7F, "b2b_cc");
        idle_cycles(1, "b2b");
    endtask

    task automatic test_reset_mid();
        int line_err;
        model_msg(8'hE0, 8'h00, 8'h40);
        drive_accept(8'hE0, 8'h00, 8'h40);
        line_err = 0;
        for (int n = 0; n <= FRAME + FRAME / 2; n++) begin
            if (n > 0) @(negedge clk);
            if (midi_tx !== line_bit(n)) line_err++;
        end
        tests++;
        if (line_err != 0) begin
            failed++;
            $display("FAIL reset_mid_pre: %0d wrong cycles, want 0", line_err);
        end
        reset_reg = 1'b1;
        @(negedge clk);
        tests++;
        if (midi_tx !== 1'b1 || cur_status !== 8'h00 || busy !== 1'b0 || msg_ready !== 1'b0 ||
            byte_sent !== 1'b0 || msg_err !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid: tx=%b cur=%02h busy=%b ready=%b sent=%b err=%b want 1 00 0 0 0 0",
                     midi_tx, cur_status, busy, msg_ready, byte_sent, msg_err);
        end
        reset_reg = 1'b0;
        model_cur = 8'h00;
        @(negedge clk);
        idle_cycles(2, "after_reset");
        send_msg(8'h80, 8'h3C, 8'h00, "post_reset_note_off");
        idle_cycles(1, "post_reset");
    endtask

    task automatic test_random();
        logic [7:0] st;
        logic [7:0] prev;
        prev = 8'h90;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0) st = 8'($urandom_range(0, 127));
            else if ($urandom_range(0, 2) == 0) st = prev;
            else st = 8'($urandom_range(128, 255));
            if (st[7]) prev = st;
            send_msg(st, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random");
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3), "random_gap");
        end
    endtask

    initial begin
        tests      = 0;
        failed     = 0;
        model_cur  = 8'h00;
        exp_err    = 1'b0;
        reset_reg  = 1'b1;
        msg_valid  = 1'b0;
        msg_status = 8'h00;
        msg_data1  = 8'h00;
        msg_data2  = 8'h00;
        test_reset();
        test_three_byte();
        test_two_byte();
        test_system();
        test_running_status();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/midi_out_tx.md
# midi_out_tx

Serial MIDI transmitter for the synthesizer controller. It accepts one complete MIDI message per handshake and derives the message length from the status byte. It serialises the bytes as a standard 31250-baud MIDI UART frame stream on `midi_tx`. It sits at the far end of the controller's MIDI path, on the same status/data-byte framing that the MIDI input side presents as `cur_status` / `midi_in_data`.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, system clock frequency.
- `BAUD`, 31250, MIDI bit rate. Bit period `BIT_CYC = CLK_HZ/BAUD` (1600 at defaults). Integer division is exact and checked at elaboration.

Ports:
- `CLOCK_50`  in  1  system clock; all logic on its rising edge.
- `reset_reg`  in  1  reset, synchronous, active-high.
- `msg_valid`  in  1  a message is presented on `msg_*`.
- `msg_ready`  out  1  block can accept a message.
- `msg_status`  in  8  status byte; bit7 must be 1.
- `msg_data1`  in  8  first data byte; bit7 is forced to 0 on transmit.
- `msg_data2`  in  8  second data byte; bit7 is forced to 0 on transmit.
- `midi_tx`  out  1  serial MIDI out; idles high.
- `busy`  out  1  a frame is being transmitted.
- `byte_sent`  out  1  one-cycle pulse at the end of each stop bit.
- `msg_err`  out  1  one-cycle pulse when a message with `msg_status[7]==0` is accepted and dropped.
- `cur_status`  out  8  last status byte transmitted (running-status register).

## Operation
- Length decode on `msg_status`:
  - 0x80–0xBF and 0xE0–0xEF: 3 bytes.
  - 0xC0–0xDF: 2 bytes.
  - 0xF1 and 0xF3: 2 bytes.
  - 0xF2: 3 bytes.
  - All other 0xF0–0xFF: 1 byte (status only). SysEx streaming is not supported.
- FSM states: IDLE → SEND_ST → SEND_D1 → SEND_D2 → IDLE.
  - Skipped states are bypassed according to the decoded length.
  - Each SEND state issues one byte and waits for frame done.
- IDLE:
  - `msg_ready`=1.
  - A transfer occurs when `msg_valid & msg_ready` on a rising edge. The inputs are captured into holding registers on that edge.
  - `msg_valid` held with `msg_ready`=0 has no effect.
- Invalid status (bit7=0): the message is accepted, nothing is transmitted, `msg_err` pulses the next cycle, and the FSM stays in IDLE.
- Frame format: start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly `BIT_CYC` cycles.
- `cur_status` update:
  - Loads the status byte when its frame starts.
  - Status bytes 0xF0–0xF7 load 0x00 (running status cancelled).
  - Realtime 0xF8–0xFF leave `cur_status` unchanged.

## Timing
- Reset values: `midi_tx`=1, `msg_ready`=0 during reset and 1 from the first cycle after reset deasserts, `busy`=0, `byte_sent`=0, `msg_err`=0, `cur_status`=0x00.
- Accept on edge k:
  - `msg_ready`=0 and `busy`=1 from edge k+1.
  - `midi_tx` start bit begins at edge k+1.
- Consecutive bytes of one message are back-to-back, with no idle gap between stop bit and next start bit.
- Message durations: 3-byte message = 30·`BIT_CYC` cycles (48000); 2-byte = 20·`BIT_CYC`; 1-byte = 10·`BIT_CYC`.
- At the end of each stop bit, `byte_sent` pulses for one cycle.
  - After the last byte, `msg_ready`=1 and `busy`=0 in the same cycle as that pulse.
  - A new message may be accepted on that edge, giving zero idle gap between messages.
- Reset mid-frame: on the next edge `midi_tx`=1, the frame is truncated, holding registers are discarded, and all outputs return to their reset values.
- Bit counter must not drift: bit boundaries are exactly `BIT_CYC` apart for any message sequence.

## Configuration
- `MIDI_TX_RUNNING_STATUS_EN` defined: running status is enabled.
  - For a channel message (0x80–0xEF) whose status equals `cur_status`, SEND_ST is skipped and only the data bytes are sent.
  - `cur_status` is cancelled by 0xF0–0xF7 and by reset.
- `MIDI_TX_RUNNING_STATUS_EN` undefined: the status byte is always sent. `cur_status` is still maintained as an observable register.

## Structure
- Shared package `midi_pkg` holds:
  - Status-class constants (`ST_NOTE_OFF`=0x8 … `ST_PITCHBEND`=0xE, `ST_SYSTEM`=0xF).
  - The `msg_len_f(status)` length-decode function.
  - The FSM state enum typedef.
- Sub-module `midi_uart_tx`, a single-byte serialiser.
  - Ports: `load` pulse, 8-bit `data`, `tx`, `done` pulse. Parameter `BIT_CYC`.
  - It contains the bit-period counter and the 4-bit bit counter.
- The top level contains the handshake, length decode, FSM, and running-status logic.

## Test plan
- Reset, then send 0x90/0x3C/0x64. The line must show frames 0x90, 0x3C, 0x64, each bit 1600 cycles, with 3 `byte_sent` pulses. `msg_ready` returns high at cycle 48000 after accept.
- Send 0xC5/0x07. Exactly 2 frames, 32000 cycles; `msg_data2` is ignored.
- Send 0xF8. One frame, `cur_status` unchanged. Then send 0xF2/0x01/0x02. Three frames, and `cur_status` becomes 0x00.
- With `MIDI_TX_RUNNING_STATUS_EN`:
  - Send 0x90/0x3C/0x64, then 0x90/0x40/0x00. Second message sends only 0x40, 0x00.
  - Then send 0xFE, then 0x90/0x43/0x50. Only 0x43, 0x50 are sent, because realtime does not cancel running status.
  - Without the macro, all status bytes are sent.
- Send status 0x3C. `msg_err` pulses once, `midi_tx` stays high, `msg_ready` stays 1.
- Assert `reset_reg` mid-way through the second byte of 0xE0/0x00/0x40. `midi_tx`=1 on the next edge, `cur_status`=0x00, and a following 0x80/0x3C/0x00 transmits cleanly with the status byte.
